// File: rtl/ccg_harness_pkg.sv
// Shared types, constants and the MISR step function for the CCG sweep harness.
package ccg_harness_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StDone
  } state_e;

  // Fibonacci LFSR x^4+x^3+1: feedback is the XOR of bits 3 and 2.
  localparam logic [3:0] LFSR4_TAPS = 4'b1100;
  localparam logic [3:0] LFSR4_SEED = 4'b0001;
  // Final state of the 15-long sequence; its successor is the seed again.
  localparam logic [3:0] LFSR4_LAST = 4'b1000;

  localparam logic [18:0] MISR_POLY_DEFAULT = 19'h40027;

  // One MISR step on a signature of 'width' bits, carried in 64-bit containers.
  function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                            input logic [63:0] poly,
                                            input logic [63:0] f,
                                            input int unsigned width);
    logic [63:0] mask;
    logic        msb;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    msb  = ((sig >> (width - 1)) & 64'd1) != 64'd0;
    return ((sig << 1) ^ (msb ? poly : 64'd0) ^ f) & mask;
  endfunction

endpackage

// File: rtl/ccg_vec_gen.sv
// Stimulus generator: exhaustive up-counter or 4-bit LFSR, plus a last-vector flag.
module ccg_vec_gen import ccg_harness_pkg::*; #(
  parameter int unsigned N_IN = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            mode_i,
  input  logic            advance_i,
  output logic [N_IN-1:0] x_o,
  output logic            last_o
);

  logic [N_IN-1:0] x_q, x_d;
  logic            mode_q, mode_d;
  logic [N_IN-1:0] cnt_next, lfsr_next, lfsr_seed, lfsr_last;

  assign cnt_next = x_q + N_IN'(1);

  // LFSR mode exists only for a 4-bit stimulus; other widths fall back to counting.
  if (N_IN == 4) begin : g_lfsr
    assign lfsr_next = {x_q[2:0], ^(x_q & LFSR4_TAPS)};
    assign lfsr_seed = LFSR4_SEED;
    assign lfsr_last = LFSR4_LAST;
  end else begin : g_no_lfsr
    assign lfsr_next = cnt_next;
    assign lfsr_seed = '0;
    assign lfsr_last = '1;
  end

  // Next vector: load the first one on start, step on each capture, else hold.
  always_comb begin
    x_d    = x_q;
    mode_d = mode_q;
    if (load_i) begin
      mode_d = mode_i;
      x_d    = mode_i ? lfsr_seed : '0;
    end else if (advance_i) begin
      x_d = mode_q ? lfsr_next : cnt_next;
    end
  end

  // Vector and latched mode registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      mode_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      mode_q <= mode_d;
    end
  end

  assign x_o    = x_q;
  assign last_o = mode_q ? (x_q == lfsr_last) : (x_q == '1);

endmodule

// File: rtl/ccg_sweep_misr.sv
// Sweep harness: drives x through a full vector set, folds each settled f into a MISR.
module ccg_sweep_misr import ccg_harness_pkg::*; #(
  parameter int unsigned       N_IN      = 4,
  parameter int unsigned       N_OUT     = 19,
  parameter int unsigned       SETTLE    = 1,
  parameter logic [N_OUT-1:0]  MISR_POLY = N_OUT'(MISR_POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature,
  output logic [N_IN:0]    vec_count
);

  localparam int unsigned   CW        = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  state_e           state_q;
  logic [CW-1:0]    settle_q;
  logic             busy_q, done_q;
  logic [N_OUT-1:0] sig_q, sig_next;
  logic [N_IN:0]    vcnt_q;
  logic             vec_load, vec_adv, vec_last;

  // Vector generator control and the MISR next value.
  always_comb begin
    vec_load = (state_q == StIdle) && start;
    vec_adv  = (state_q == StCapture) && !abort;
    sig_next = N_OUT'(misr_step(64'(sig_q), 64'(MISR_POLY), 64'(f), N_OUT));
  end

  ccg_vec_gen #(
    .N_IN(N_IN)
  ) u_vec_gen (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (vec_load),
    .mode_i   (mode),
    .advance_i(vec_adv),
    .x_o      (x),
    .last_o   (vec_last)
  );

  // Sweep FSM with registered busy/done, signature and vector count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= '0;
      vcnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSettle;
            settle_q <= SETTLE_LD;
            busy_q   <= 1'b1;
            sig_q    <= '0;
            vcnt_q   <= '0;
          end
        end
        StSettle: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (settle_q == CW'(1)) begin
            state_q <= StCapture;
          end else begin
            settle_q <= settle_q - CW'(1);
          end
        end
        StCapture: begin
          // Abort wins over the capture: signature and count keep partial values.
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            sig_q  <= sig_next;
            vcnt_q <= vcnt_q + (N_IN + 1)'(1);
            if (vec_last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StSettle;
              settle_q <= SETTLE_LD;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;
  assign vec_count = vcnt_q;

endmodule

// File: tb/tb_ccg_sweep_misr.sv
// Scoreboard bench: two harness instances (SETTLE=1 and SETTLE=3) share stimulus.
module tb_ccg_sweep_misr;

  localparam int unsigned POLY = 32'h40027;

  typedef struct {
    logic [18:0] sig;
    int          vcnt;
    int          len;
    int          done_n;
    int          done_at;
    int unsigned hash;
    int          zeros;
    bit          is_reset;
  } exp_t;

  logic        clk, rst_n, start, mode, abort;
  logic [3:0]  x_w   [2];
  logic [18:0] f_w   [2];
  logic [18:0] sig_w [2];
  logic [4:0]  vc_w  [2];
  logic        busy_w [2];
  logic        done_w [2];

  int          f_kind;
  logic [18:0] tbl [16];
  exp_t        exp_q [2][$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference model: a sweep described by its vector list and cycle budget.
  function automatic exp_t model(input bit lfsr, input int s, input int a, input int fk);
    exp_t        e;
    int          vec [16];
    int          v, full, caps, nd, xv;
    int unsigned sg, fv;
    v      = lfsr ? 15 : 16;
    vec[0] = lfsr ? 1 : 0;
    for (int i = 1; i < 16; i++)
      vec[i] = lfsr ? (((vec[i-1] * 2) % 16) + (((vec[i-1] >> 3) ^ (vec[i-1] >> 2)) & 1)) : i;
    full = v * (s + 1);
    if (a == 0 || a > full) begin
      e.len = full + 1; e.done_n = 1; e.done_at = full + 1; caps = v; nd = full;
    end else begin
      e.len = a; e.done_n = 0; e.done_at = 0; caps = (a - 1) / (s + 1); nd = a;
    end
    sg = 0;
    for (int j = 0; j < caps; j++) begin
      fv = (fk == 0) ? 0 : (fk == 1) ? 1 : int'(tbl[vec[j]]);
      sg = ((sg * 2) % (1 << 19)) ^ ((sg >= (1 << 18)) ? POLY : 0) ^ fv;
    end
    e.hash  = 0;
    e.zeros = 0;
    for (int k = 1; k <= nd; k++) begin
      xv     = vec[(k - 1) / (s + 1)];
      e.hash = e.hash * 31 + xv;
      if (xv == 0) e.zeros++;
    end
    e.sig      = sg[18:0];
    e.vcnt     = caps;
    e.is_reset = 1'b0;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned S = (g == 0) ? 1 : 3;

    assign f_w[g] = (f_kind == 0) ? 19'd0 : (f_kind == 1) ? 19'd1 : tbl[x_w[g]];

    ccg_sweep_misr #(
      .N_IN     (4),
      .N_OUT    (19),
      .SETTLE   (S),
      .MISR_POLY(19'h40027)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .abort    (abort),
      .x        (x_w[g]),
      .f        (f_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .signature(sig_w[g]),
      .vec_count(vc_w[g])
    );

    int          run_len  = 0;
    int          done_n   = 0;
    int          done_at  = 0;
    int          zeros    = 0;
    int unsigned hash     = 0;
    bit          prev_busy = 0;

    // Reset forces outputs to idle values without waiting for a clock.
    always @(negedge rst_n) begin
      #1;
      chk($sformatf("d%0d rst x", g), x_w[g], 0);
      chk($sformatf("d%0d rst busy", g), busy_w[g], 0);
      chk($sformatf("d%0d rst done", g), done_w[g], 0);
      chk($sformatf("d%0d rst sig", g), sig_w[g], 0);
      chk($sformatf("d%0d rst vcnt", g), vc_w[g], 0);
    end

    // Monitor: trace each busy span, score it when busy falls.
    always @(negedge clk) begin
      exp_t e;
      if (busy_w[g]) begin
        if (!prev_busy) begin
          run_len = 0; done_n = 0; done_at = 0; zeros = 0; hash = 0;
        end
        run_len++;
        if (done_w[g]) begin
          done_n++;
          done_at = run_len;
        end else begin
          hash = hash * 31 + int'(x_w[g]);
          if (x_w[g] == 4'd0) zeros++;
        end
      end else begin
        if (done_w[g]) chk($sformatf("d%0d done_while_idle", g), 1, 0);
        if (prev_busy) begin
          if (exp_q[g].size() == 0) begin
            chk($sformatf("d%0d unexpected_run", g), 1, 0);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("d%0d sig", g), sig_w[g], e.sig);
            chk($sformatf("d%0d vec_count", g), vc_w[g], e.vcnt);
            chk($sformatf("d%0d busy_len", g), run_len, e.len);
            chk($sformatf("d%0d done_pulses", g), done_n, e.done_n);
            chk($sformatf("d%0d done_at", g), done_at, e.done_at);
            if (e.is_reset) begin
              chk($sformatf("d%0d x_after_rst", g), x_w[g], 0);
            end else begin
              chk($sformatf("d%0d x_trace", g), hash, e.hash);
              chk($sformatf("d%0d x_zero_cycles", g), zeros, e.zeros);
            end
          end
        end
      end
      prev_busy = busy_w[g];
    end
  end

  // One sweep: a = abort edge (0 none), rst_at = reset edge (0 none).
  task automatic run(input bit lfsr, input int fk, input int a, input int rst_at,
                     input bit extra_start);
    exp_t e;
    bit   ended = 0;
    mode   = lfsr;
    f_kind = fk;
    for (int g = 0; g < 2; g++) begin
      if (rst_at > 0) begin
        e = '{sig: '0, vcnt: 0, len: rst_at, done_n: 0, done_at: 0, hash: 0, zeros: 0,
              is_reset: 1'b1};
      end else begin
        e = model(lfsr, (g == 0) ? 1 : 3, a, fk);
      end
      exp_q[g].push_back(e);
    end
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int ed = 1; ed <= 200; ed++) begin
      if (ed == a) abort = 1;
      if (extra_start && ed == 7) begin start = 1; mode = !lfsr; end
      if (rst_at > 0 && ed == rst_at + 1) rst_n = 0;
      if (rst_at > 0 && ed == rst_at + 3) rst_n = 1;
      @(posedge clk); #1;
      abort = 0; start = 0; mode = lfsr;
      if (ed >= 3 && rst_n && !busy_w[0] && !busy_w[1]) begin
        ended = 1;
        break;
      end
    end
    rst_n = 1;
    chk("run_terminates", ended, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic new_table();
    for (int i = 0; i < 16; i++) tbl[i] = 19'($urandom);
  endtask

  initial begin
    clk = 0; rst_n = 1; start = 0; mode = 0; abort = 0; f_kind = 0;
    new_table();
    #2 rst_n = 0;
    #20;
    @(negedge clk) rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    run(1'b0, 0, 0, 0, 1'b0);   // exhaustive, f = 0
    run(1'b0, 1, 0, 0, 1'b0);   // exhaustive, f = 1 -> 0x0FFFF
    run(1'b1, 1, 0, 0, 1'b0);   // LFSR, f = 1 -> 0x07FFF
    run(1'b0, 2, 0, 0, 1'b1);   // benchmark table, stray start mid-sweep
    run(1'b1, 2, 0, 0, 1'b0);
    run(1'b0, 2, 11, 0, 1'b0);  // abort: SETTLE=1 instance stops after 5 vectors
    run(1'b0, 2, 0, 0, 1'b0);   // full sweep after abort
    run(1'b1, 2, 0, 6, 1'b0);   // reset mid-SETTLE
    run(1'b1, 2, 0, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      new_table();
      run(1'($urandom_range(0, 1)), 2, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0,
          0, 1'b0);
    end

    for (int g = 0; g < 2; g++) chk($sformatf("d%0d queue_drained", g), exp_q[g].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
